// File: rtl/dcache_axi_rd_pkg.sv
// Shared definitions for the data-cache AXI read engine: request types,
// FSM states, AXI burst/size constants and AR address/length helpers.
package dcache_axi_rd_pkg;

  // Upstream request type; the fourth code is reserved and behaves like a line read.
  typedef enum logic [1:0] {
    RD_WORD  = 2'b00,
    RD_LINE  = 2'b01,
    RD_DLINE = 2'b10,
    RD_RSVD  = 2'b11
  } rd_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_AR   = 2'b01,
    S_R    = 2'b10
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  // Fold the reserved encoding onto the single-line read.
  function automatic rd_type_e norm_type(input logic [1:0] t);
    rd_type_e r;
    r = rd_type_e'(t);
    if (r == RD_RSVD) r = RD_LINE;
    return r;
  endfunction

  // Word reads keep the exact address; line reads align to 16 bytes.
  function automatic logic [31:0] ar_addr_of(input rd_type_e t, input logic [31:0] a);
    if (t == RD_WORD) return a;
    return {a[31:4], 4'b0000};
  endfunction

  // AXI3 burst length minus one: 1, 4 or 8 beats.
  function automatic logic [3:0] ar_len_of(input rd_type_e t);
    case (t)
      RD_WORD:  return 4'd0;
      RD_DLINE: return 4'd7;
      default:  return 4'd3;
    endcase
  endfunction

endpackage

// File: rtl/dcache_axi_rd.sv
// Single-outstanding AXI3 read engine for the data cache / prefetcher.
// Issues one AR burst per accepted request, assembles the returned words
// into a 256-bit buffer and pulses ret_half / ret_valid when data is ready.
module dcache_axi_rd
  import dcache_axi_rd_pkg::*;
#(
  parameter logic [3:0] ARID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  // upstream request / response
  input  logic         rd_req,
  input  logic [1:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_half,
  output logic [255:0] ret_data,
  // AXI AR channel
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [3:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  // AXI R channel
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  state_e         state_q, state_d;
  rd_type_e       type_q, type_d;
  logic [31:0]    addr_q, addr_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           full_q, full_d;   // all 8 words written; later beats are dropped
  logic [255:0]   data_q, data_d;
  logic           ret_valid_q, ret_valid_d;
  logic           ret_half_q, ret_half_d;

  // rid and rresp are deliberately ignored: errored beats are stored as received.
  logic unused_r_sideband;
  assign unused_r_sideband = ^{rid, rresp};

  // State and datapath registers; asynchronous reset abandons any burst in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      type_q      <= RD_WORD;
      addr_q      <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      data_q      <= '0;
      ret_valid_q <= 1'b0;
      ret_half_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      data_q      <= data_d;
      ret_valid_q <= ret_valid_d;
      ret_half_q  <= ret_half_d;
    end
  end

  // Next-state logic: accept in IDLE, hold AR until arready, collect beats until rlast.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    full_d      = full_q;
    data_d      = data_q;
    ret_valid_d = 1'b0;
    ret_half_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          type_d  = norm_type(rd_type);
          addr_d  = rd_addr;
          data_d  = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          if (!full_q) data_d[{cnt_q, 5'b00000} +: 32] = rdata;
          // Counter saturates at the last word; the flag stops further writes.
          if (cnt_q == 3'd7) full_d = 1'b1;
          else               cnt_d  = cnt_q + 3'd1;
          if (rlast) begin
            ret_valid_d = 1'b1;
            state_d     = S_IDLE;
          end else if (type_q == RD_DLINE && cnt_q == 3'd3 && !full_q) begin
            // First line complete; suppressed if the burst ends here so the
            // two pulses never coincide.
            ret_half_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_rdy    = (state_q == S_IDLE);
  assign arvalid   = (state_q == S_AR);
  assign rready    = (state_q == S_R);
  assign arid      = ARID;
  assign araddr    = ar_addr_of(type_q, addr_q);
  assign arlen     = ar_len_of(type_q);
  assign arsize    = AXI_SIZE_4B;
  assign arburst   = AXI_BURST_INCR;
  assign ret_valid = ret_valid_q;
  assign ret_half  = ret_half_q;
  assign ret_data  = data_q;

endmodule

// File: tb/tb_dcache_axi_rd.sv
// Scoreboard bench for dcache_axi_rd: expectations are queued when a request
// is issued and consumed by a monitor when the DUT shows AR / ret_half / ret_valid.
module tb_dcache_axi_rd;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rd_req;
  logic [1:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, ret_half;
  logic [255:0] ret_data;
  logic [3:0]   arid, arlen;
  logic [31:0]  araddr;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int acc_cnt  = 0;
  int ret_cyc  = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_exp_t;

  ar_exp_t      exp_ar_q[$];
  logic [255:0] exp_ret_q[$];
  logic [255:0] exp_half_q[$];

  dcache_axi_rd #(.ARID(4'd1)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_half(ret_half), .ret_data(ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Words 1..n (capped at 8) in ascending word slots.
  function automatic logic [255:0] words(input int n);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < n && i < 8; i++) w[32*i +: 32] = 32'(i + 1);
    return w;
  endfunction

  // Monitor: sample on the falling edge, consume scoreboard entries.
  always @(negedge clk) begin
    if (resetn) begin
      if (arvalid && arready) begin
        check_eq("ar_expected", 256'(exp_ar_q.size() != 0), 256'd1);
        if (exp_ar_q.size() != 0) begin
          ar_exp_t e;
          e = exp_ar_q.pop_front();
          check_eq("araddr", araddr, e.addr);
          check_eq("arlen", arlen, e.len);
          check_eq("arid", arid, 4'd1);
          check_eq("arsize_arburst", {arsize, arburst}, {3'b010, 2'b01});
        end
      end
      if (ret_valid) begin
        ret_cyc = cyc;
        check_eq("ret_valid_expected", 256'(exp_ret_q.size() != 0), 256'd1);
        check_eq("ret_half_with_valid", ret_half, 1'b0);
        if (exp_ret_q.size() != 0) check_eq("ret_data", ret_data, exp_ret_q.pop_front());
      end
      if (ret_half) begin
        check_eq("ret_half_expected", 256'(exp_half_q.size() != 0), 256'd1);
        if (exp_half_q.size() != 0) check_eq("half_data", ret_data, exp_half_q.pop_front());
      end
      if (rd_req && rd_rdy) begin
        acc_cyc = cyc;
        acc_cnt++;
      end
    end
  end

  task automatic send_req(input logic [1:0] t, input logic [31:0] a);
    int n;
    n = 0;
    while (!rd_rdy && n < 200) begin @(posedge clk); #1; n++; end
    if (!rd_rdy) check_eq("rd_rdy_timeout", rd_rdy, 1'b1);
    rd_req = 1'b1; rd_type = t; rd_addr = a;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic do_ar(input int hold, input logic [31:0] ea, input logic [3:0] el, input bit bait);
    int n;
    n = 0;
    while (!arvalid && n < 100) begin @(posedge clk); #1; n++; end
    if (!arvalid) check_eq("arvalid_timeout", arvalid, 1'b1);
    if (bait) begin rvalid = 1'b1; rdata = 32'hBAD0BAD0; rlast = 1'b1; end
    for (int k = 0; k < hold; k++) begin
      check_eq("hold_araddr", araddr, ea);
      check_eq("hold_arlen", arlen, el);
      check_eq("hold_flags", {arvalid, rd_rdy, rready}, 3'b100);
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rlast = 1'b0;
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
  endtask

  task automatic do_beats(input int n, input bit gaps, input bit with_last);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3) == 1) begin
        rvalid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
      end
      rvalid = 1'b1;
      rdata  = 32'(i + 1);
      rlast  = with_last && (i == n - 1);
      rid    = 4'($urandom);
      rresp  = 2'($urandom);
      begin
        int w;
        w = 0;
        while (!rready && w < 100) begin @(posedge clk); #1; w++; end
        if (!rready) check_eq("rready_timeout", rready, 1'b1);
      end
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic expect_txn(input logic [31:0] a, input logic [3:0] l, input logic [255:0] r);
    ar_exp_t e;
    e.addr = a; e.len = l;
    exp_ar_q.push_back(e);
    exp_ret_q.push_back(r);
  endtask

  initial begin
    resetn = 1'b0; rd_req = 1'b0; rd_type = '0; rd_addr = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_flags", {rd_rdy, arvalid, rready, ret_valid, ret_half}, 5'b10000);
    check_eq("reset_data", ret_data, 256'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Single word at minimum latency: AR and R ready in advance.
    expect_txn(32'h1FC0_0004, 4'd0, 256'h0DEADBEEF);
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEADBEEF; rlast = 1'b1;
    send_req(2'b00, 32'h1FC0_0004);
    repeat (2) begin @(posedge clk); #1; end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    @(posedge clk); #1;
    check_eq("latency_word", 256'(ret_cyc - acc_cyc), 256'd3);
    check_eq("data_held", ret_data, 256'h0DEADBEEF);

    // One line, unaligned address.
    expect_txn(32'h8000_0010, 4'd3, words(4));
    send_req(2'b01, 32'h8000_0018);
    do_ar(0, 32'h8000_0010, 4'd3, 1'b0);
    do_beats(4, 1'b0, 1'b1);

    // Two lines with rvalid gaps: half pulse after beat 4.
    expect_txn(32'h8000_0020, 4'd7, words(8));
    exp_half_q.push_back(words(4));
    send_req(2'b10, 32'h8000_0020);
    do_ar(0, 32'h8000_0020, 4'd7, 1'b0);
    do_beats(8, 1'b1, 1'b1);

    // arready held off for 5 cycles while a stray R beat is offered.
    expect_txn(32'h1234_5670, 4'd3, words(4));
    send_req(2'b01, 32'h1234_567C);
    do_ar(5, 32'h1234_5670, 4'd3, 1'b1);
    do_beats(4, 1'b0, 1'b1);

    // Reserved type behaves as a line read.
    expect_txn(32'h0000_0100, 4'd3, words(4));
    send_req(2'b11, 32'h0000_0104);
    do_ar(0, 32'h0000_0100, 4'd3, 1'b0);
    do_beats(4, 1'b0, 1'b1);

    // Overlong burst: beats 9 and 10 are dropped.
    expect_txn(32'h0000_1000, 4'd7, words(8));
    exp_half_q.push_back(words(4));
    send_req(2'b10, 32'h0000_1008);
    do_ar(0, 32'h0000_1000, 4'd7, 1'b0);
    do_beats(10, 1'b0, 1'b1);

    // Request held during R is taken only once the response is returned.
    expect_txn(32'h0000_0040, 4'd3, words(4));
    send_req(2'b01, 32'h0000_0040);
    do_ar(0, 32'h0000_0040, 4'd3, 1'b0);
    begin
      int a0;
      a0 = acc_cnt;
      expect_txn(32'h0000_0208, 4'd0, words(1));
      rd_req = 1'b1; rd_type = 2'b00; rd_addr = 32'h0000_0208;
      check_eq("rdy_low_in_r", rd_rdy, 1'b0);
      do_beats(4, 1'b0, 1'b1);
      check_eq("rdy_at_ret", rd_rdy, 1'b1);
      @(posedge clk); #1;
      rd_req = 1'b0;
      check_eq("accept_count", 256'(acc_cnt - a0), 256'd1);
      check_eq("accept_at_ret_cycle", 256'(acc_cyc - ret_cyc), 256'd0);
      check_eq("data_cleared", ret_data, 256'd0);
    end
    do_ar(0, 32'h0000_0208, 4'd0, 1'b0);
    do_beats(1, 1'b0, 1'b1);

    // Reset mid-burst after two beats.
    begin
      ar_exp_t e;
      e.addr = 32'h8000_0040; e.len = 4'd7;
      exp_ar_q.push_back(e);
    end
    send_req(2'b10, 32'h8000_0040);
    do_ar(0, 32'h8000_0040, 4'd7, 1'b0);
    do_beats(2, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_eq("midreset_flags", {rd_rdy, arvalid, rready, ret_valid, ret_half}, 5'b10000);
    check_eq("midreset_data", ret_data, 256'd0);
    @(posedge clk); #3;
    resetn = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    check_eq("post_reset_data", ret_data, 256'd0);

    repeat (3) begin @(posedge clk); #1; end
    check_eq("ar_drained", 256'(exp_ar_q.size()), 256'd0);
    check_eq("ret_drained", 256'(exp_ret_q.size()), 256'd0);
    check_eq("half_drained", 256'(exp_half_q.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
